spike_input_injector: RTL

SPIKE_INPUT_INJECTOR -- requirements
Module: spike_input_injector

---
 rtl/spike_input_injector.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/spike_input_injector.sv
// -----------------------------------------------------------------------------
// spike_input_injector
//
// Host-side packet injector feeding the west port of core 0. The host writes
// spike packets into a first-word-fall-through FIFO, then commits them as a
// batch. The batch is held back until the next global tick. From that tick on,
// the packets are offered to core 0, which pops them through its west-port
// read strobe. A write made after the commit waits for a later batch.
//
// Ports
//   clk           single rising-edge clock
//   reset_n       asynchronous active-low reset
//   tick          one-cycle global tick pulse (shared with the cores)
//   host_wen      host write strobe for host_packet
//   host_packet   packet {dx[29:21], dy[20:12], delivery tick[11:8], axon[7:0]}
//   host_commit   close the current batch for release on the next tick
//   host_flush    synchronous discard of all FIFO contents
//   err_clr       clear the sticky error flags
//   ren_in        pop request from core 0 (its ren_out_west)
//   dout          head packet, to west_in of core 0
//   empty_out     no releasable packet, to empty_in_west of core 0
//   host_full     FIFO occupancy equals DEPTH
//   host_count    FIFO occupancy
//   batch_done    one-cycle pulse after the last packet of a batch is popped
//   state         IDLE=0, ARMED=1, RELEASE=2
//   overflow_err  sticky: a host write was dropped because the FIFO was full
//   overrun_err   sticky: a tick arrived while a batch was still releasing
//
// Handshake: the consumer side is a read-strobe interface. When empty_out is 0,
// dout holds the head packet. A cycle with ren_in=1 and empty_out=0 takes that
// packet at the rising edge. The DUT ignores ren_in while empty_out is 1.
// -----------------------------------------------------------------------------
module spike_input_injector #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick,
    input  logic              host_wen,
    input  logic [29:0]       host_packet,
    input  logic              host_commit,
    input  logic              host_flush,
    input  logic              err_clr,
    input  logic              ren_in,
    output logic [29:0]       dout,
    output logic              empty_out,
    output logic              host_full,
    output logic [ADDR_W:0]   host_count,
    output logic              batch_done,
    output logic [1:0]        state,
    output logic              overflow_err,
    output logic              overrun_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE        = (ADDR_W+1)'(1);

    logic [29:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   batch_rem;
    logic [ADDR_W:0]   uncommitted;
    logic [1:0]        state_q;
    logic [1:0]        state_d;
    logic              batch_done_q;
    logic              ovf_q;
    logic              ovr_q;

    logic              releasing;
    logic              wr_accept;
    logic              pop;
    logic              commit_ok;
    logic              last_pop;

    // A full FIFO is judged from the registered occupancy. A write is therefore
    // refused in the cycle the FIFO is full, even if a pop frees a slot at the
    // same edge.
    assign host_full   = (count == FULL_LEVEL);
    assign uncommitted = count - batch_rem;
    assign wr_accept   = host_wen && !host_full && !host_flush;
    assign pop         = ren_in && !empty_out && !host_flush;
    // Both counters are registered values. A write in the commit cycle is
    // therefore not counted in the batch that this commit loads.
    assign commit_ok   = (state_q == ST_IDLE) && host_commit && (uncommitted != '0)
                         && !host_flush;
    assign last_pop    = pop && (batch_rem == ONE);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        if (host_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (commit_ok) state_d = ST_ARMED;
                ST_ARMED:   if (tick)      state_d = ST_RELEASE;
                ST_RELEASE: if (last_pop)  state_d = ST_IDLE;
                default:                   state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        releasing = (state_q == ST_RELEASE) && (batch_rem != '0);
        empty_out = !releasing;
    end

    // ---------------- FIFO storage (no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= host_packet;
    end

    assign dout = mem[rd_ptr];

    // ---------------- pointers, occupancy, batch counter ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            batch_rem <= '0;
        end else if (host_flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            batch_rem <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({wr_accept, pop})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase
            // A commit is accepted only in IDLE and a pop only in RELEASE,
            // so the two never happen in the same cycle.
            if (commit_ok)  batch_rem <= uncommitted;
            else if (pop)   batch_rem <= batch_rem - ONE;
        end
    end

    // ---------------- batch completion pulse ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) batch_done_q <= 1'b0;
        else          batch_done_q <= last_pop;
    end

    // ---------------- sticky errors (a new event beats err_clr) ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            if (host_wen && host_full) ovf_q <= 1'b1;
            else if (err_clr)          ovf_q <= 1'b0;

            if (tick && (state_q == ST_RELEASE) && !host_flush) ovr_q <= 1'b1;
            else if (err_clr)                                   ovr_q <= 1'b0;
        end
    end

    assign host_count   = count;
    assign batch_done   = batch_done_q;
    assign state        = state_q;
    assign overflow_err = ovf_q;
    assign overrun_err  = ovr_q;

endmodule
